// File: rtl/param_fifo_pkg.sv
// rtl/param_fifo_pkg.sv - shared defaults and pointer-width helper for param_fifo
package param_fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Number of bits needed to address 'depth' entries (depth is a power of two).
  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// rtl/param_fifo_mem.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
module param_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // Storage is deliberately not reset; control logic never exposes stale words.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parameterised single-clock FIFO with level flags and error pulses
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0,
  localparam int AW      = ptr_width(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             writep,
  input  logic             readp,
  output logic [WIDTH-1:0] dout,
  output logic             emptyp,
  output logic             fullp,
  output logic             almost_emptyp,
  output logic             almost_fullp,
  output logic [CW-1:0]    count,
  output logic             overflowp,
  output logic             underflowp
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;
  logic             r_unf;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_rd_data;

  assign emptyp        = (r_count == '0);
  assign fullp         = (r_count == DEPTH_C);
  assign almost_emptyp = (r_count <= AE_C);
  assign almost_fullp  = (r_count >= AF_C);
  assign count         = r_count;
  assign overflowp     = r_ovf;
  assign underflowp    = r_unf;

  assign w_wr_acc = writep & ~fullp;
  assign w_rd_acc = readp & ~emptyp;

  param_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (din),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_ovf <= writep & fullp;
      r_unf <= readp & emptyp;
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) begin
        r_rptr <= r_rptr + AW'(1);
        r_dout <= w_rd_data;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // In FWFT mode r_dout still tracks the last popped word, which is what
  // dout holds once the FIFO drains.
  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = emptyp ? r_dout : w_rd_data;
    end else begin : g_reg
      assign dout = r_dout;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - self-checking bench for param_fifo, registered and FWFT instances
module tb_param_fifo;

  logic        clk;
  logic        rstn;
  logic [15:0] din;
  logic        writep;
  logic        readp;

  logic [15:0] dout0, dout1;
  logic        empty0, full0, ae0, af0, ovf0, unf0;
  logic        empty1, full1, ae1, af1, ovf1, unf1;
  logic [3:0]  count0, count1;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored words plus the last word popped.
  logic [15:0] q[$];
  logic [15:0] exp_last;
  bit          exp_ovf;
  bit          exp_unf;

  param_fifo #(.WIDTH(16), .DEPTH(8), .FWFT(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .din(din), .writep(writep), .readp(readp),
    .dout(dout0), .emptyp(empty0), .fullp(full0), .almost_emptyp(ae0),
    .almost_fullp(af0), .count(count0), .overflowp(ovf0), .underflowp(unf0)
  );

  param_fifo #(.WIDTH(16), .DEPTH(8), .FWFT(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .din(din), .writep(writep), .readp(readp),
    .dout(dout1), .emptyp(empty1), .fullp(full1), .almost_emptyp(ae1),
    .almost_fullp(af1), .count(count1), .overflowp(ovf1), .underflowp(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [15:0] exp_fwft;
    n = q.size();
    exp_fwft = (n > 0) ? q[0] : exp_last;
    chk({tag, ".count0"}, 32'(count0), 32'(n));
    chk({tag, ".count1"}, 32'(count1), 32'(n));
    chk({tag, ".empty0"}, 32'(empty0), 32'(n == 0));
    chk({tag, ".empty1"}, 32'(empty1), 32'(n == 0));
    chk({tag, ".full0"},  32'(full0),  32'(n == 8));
    chk({tag, ".full1"},  32'(full1),  32'(n == 8));
    chk({tag, ".ae0"},    32'(ae0),    32'(n <= 2));
    chk({tag, ".ae1"},    32'(ae1),    32'(n <= 2));
    chk({tag, ".af0"},    32'(af0),    32'(n >= 6));
    chk({tag, ".af1"},    32'(af1),    32'(n >= 6));
    chk({tag, ".ovf0"},   32'(ovf0),   32'(exp_ovf));
    chk({tag, ".ovf1"},   32'(ovf1),   32'(exp_ovf));
    chk({tag, ".unf0"},   32'(unf0),   32'(exp_unf));
    chk({tag, ".unf1"},   32'(unf1),   32'(exp_unf));
    chk({tag, ".dout0"},  32'(dout0),  32'(exp_last));
    chk({tag, ".dout1"},  32'(dout1),  32'(exp_fwft));
  endtask

  // One clock cycle of stimulus; model is advanced from pre-edge state.
  task automatic cyc(input string tag, input bit w, input bit r, input logic [15:0] d);
    bit full, empty;
    writep = w;
    readp  = r;
    din    = d;
    @(posedge clk);
    full    = (q.size() == 8);
    empty   = (q.size() == 0);
    exp_ovf = w && full;
    exp_unf = r && empty;
    if (r && !empty) exp_last = q.pop_front();
    if (w && !full) q.push_back(d);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    exp_last = 16'h0000;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  initial begin
    rstn   = 1'b0;
    writep = 1'b0;
    readp  = 1'b0;
    din    = 16'h0000;
    model_reset();
    #2;
    check_all("reset");
    #10;
    rstn = 1'b1;
    @(negedge clk);

    // Basic write three, read three
    cyc("w1111", 1, 0, 16'h1111);
    cyc("w2222", 1, 0, 16'h2222);
    cyc("w3333", 1, 0, 16'h3333);
    cyc("r1", 0, 1, 16'h0);
    cyc("r2", 0, 1, 16'h0);
    cyc("r3", 0, 1, 16'h0);
    cyc("idle_a", 0, 0, 16'h0);

    // Underflow on empty, simultaneous write still accepted afterwards
    cyc("unf", 0, 1, 16'h0);
    cyc("unf_clear", 0, 0, 16'h0);
    cyc("unf_wr", 1, 1, 16'hBEEF);
    cyc("drain_beef", 0, 1, 16'h0);

    // Fill to full, overflow, overflow with concurrent read, drain
    for (int i = 1; i <= 8; i++) cyc("fill", 1, 0, 16'(i));
    cyc("ovf", 1, 0, 16'h0009);
    cyc("ovf_clear", 0, 0, 16'h0);
    cyc("ovf_rd", 1, 1, 16'h00AA);
    cyc("refill", 1, 0, 16'h0010);
    for (int i = 0; i < 8; i++) cyc("drain", 0, 1, 16'h0);
    cyc("idle_b", 0, 0, 16'h0);

    // Steady state at count 4 with read+write across pointer wrap
    for (int i = 0; i < 4; i++) cyc("pre4", 1, 0, 16'(16'h0100 + i));
    for (int i = 0; i < 10; i++) cyc("both", 1, 1, 16'(16'h0200 + i));
    for (int i = 0; i < 4; i++) cyc("drain4", 0, 1, 16'h0);

    // Fall-through: word visible on the FWFT instance without a read
    cyc("wa5a5", 1, 0, 16'hA5A5);
    cyc("hold_a5a5", 0, 0, 16'h0);
    cyc("ra5a5", 0, 1, 16'h0);

    // Randomised traffic, write-heavy then read-heavy
    for (int i = 0; i < 400; i++) begin
      bit w, r;
      w = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
      r = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
      cyc("rand", w, r, 16'($urandom));
    end
    for (int i = 0; i < 9; i++) cyc("rand_drain", 0, 1, 16'h0);

    // Asynchronous reset mid-cycle with five entries stored
    for (int i = 0; i < 5; i++) cyc("pre_rst", 1, 0, 16'(16'h0300 + i));
    writep = 1'b0;
    readp  = 1'b0;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    check_all("rst_held");
    rstn = 1'b1;
    #1;
    cyc("w0042", 1, 0, 16'h0042);
    cyc("r0042", 0, 1, 16'h0);
    cyc("idle_c", 0, 0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
